// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage issue bus and hazard/forwarding controls shared by the scoreboard and its driver.
interface hazard_scoreboard_unit_if #(
   parameter int REG_AW     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int CNT_W      = 16
);
   localparam int FW = $clog2(PIPE_DEPTH);

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              flush;
   logic              stall;
   logic [FW-1:0]     fwd_a;
   logic [FW-1:0]     fwd_b;
   logic              ex_valid;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
      input  stall, fwd_a, fwd_b, ex_valid, stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read, flush,
      output stall, fwd_a, fwd_b, ex_valid, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// In-order pipeline hazard scoreboard: load-use stall, flush kill and EX operand forwarding
// from a shift register of in-flight destinations (entry 0 = EX).
module hazard_scoreboard_unit #(
   parameter int REG_AW     = 5,
   parameter int PIPE_DEPTH = 3,
   parameter int LOAD_LAT   = 1,
   parameter int BR_STAGE   = 1,
   parameter int CNT_W      = 16
) (
   input logic clk,
   input logic rst,
   hazard_scoreboard_unit_if.slave bus
);
   localparam int FW = $clog2(PIPE_DEPTH);

   if (PIPE_DEPTH < 2 || PIPE_DEPTH > 8) begin : g_bad_depth
      $error("hazard_scoreboard_unit: PIPE_DEPTH must be 2..8");
   end
   if (LOAD_LAT < 1 || LOAD_LAT > PIPE_DEPTH - 2) begin : g_bad_lat
      $error("hazard_scoreboard_unit: LOAD_LAT must be 1..PIPE_DEPTH-2");
   end
   if (BR_STAGE < 0 || BR_STAGE > PIPE_DEPTH - 1) begin : g_bad_br
      $error("hazard_scoreboard_unit: BR_STAGE must be 0..PIPE_DEPTH-1");
   end

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] rd;
      logic              is_load;
   } entry_t;

   entry_t [PIPE_DEPTH-1:0] ent_q, ent_d;
   logic [REG_AW-1:0]       src_a_q, src_a_d, src_b_q, src_b_d;
   logic                    use_b_q, use_b_d;
   logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic [PIPE_DEPTH-1:0] live, stall_hit;
   logic [PIPE_DEPTH-1:1] rdy, ma, mb;
   logic                  stall;
   logic [FW-1:0]         fwd_a, fwd_b;

   for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_ent
      // A load at entry k still blocks the ID consumer if it won't be ready when that consumer reaches EX.
      localparam bit LD_BLK = (k < LOAD_LAT);
      assign live[k]      = ent_q[k].valid & ent_q[k].wr & (ent_q[k].rd != '0);
      assign stall_hit[k] = live[k] & ent_q[k].is_load & LD_BLK &
                            ((ent_q[k].rd == bus.id_rs) |
                             (bus.id_uses_rt & (ent_q[k].rd == bus.id_rt)));
      if (k > 0) begin : g_fwd
         localparam bit LD_RDY = (k >= LOAD_LAT + 1);
         assign rdy[k] = live[k] & (~ent_q[k].is_load | LD_RDY);
         assign ma[k]  = live[k] & (ent_q[k].rd == src_a_q);
         assign mb[k]  = live[k] & use_b_q & (ent_q[k].rd == src_b_q);
      end
   end

   assign stall = bus.id_valid & (|stall_hit) & ~bus.flush;

   // Youngest matching producer wins; if it is not yet ready nothing usable exists, so select regfile.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
         if (ma[k]) fwd_a = rdy[k] ? FW'(k) : '0;
         if (mb[k]) fwd_b = rdy[k] ? FW'(k) : '0;
      end
      if (!ent_q[0].valid) begin
         fwd_a = '0;
         fwd_b = '0;
      end
   end

   always_comb begin
      ent_d   = '0;
      src_a_d = src_a_q;
      src_b_d = src_b_q;
      use_b_d = use_b_q;
      for (int k = 1; k < PIPE_DEPTH; k++) ent_d[k] = ent_q[k-1];
      if (bus.id_valid && !stall && !bus.flush) begin
         ent_d[0].valid   = 1'b1;
         ent_d[0].wr      = bus.id_reg_write;
         ent_d[0].rd      = bus.id_rd;
         ent_d[0].is_load = bus.id_mem_read;
         src_a_d          = bus.id_rs;
         src_b_d          = bus.id_rt;
         use_b_d          = bus.id_uses_rt;
      end
      if (bus.flush) begin
         for (int k = 0; k < PIPE_DEPTH; k++)
            if (k < BR_STAGE) ent_d[k].valid = 1'b0;
      end
      stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (bus.flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_q       <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         use_b_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ent_q       <= ent_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         use_b_q     <= use_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall       = stall;
   assign bus.fwd_a       = fwd_a;
   assign bus.fwd_b       = fwd_b;
   assign bus.ex_valid    = ent_q[0].valid;
   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: issue tasks queue expected EX forwarding selects, negedge monitors pop and compare.
module tb_hazard_scoreboard_unit;
   logic clk = 1'b0;
   logic rst0, rst1;
   int   checks = 0;
   int   failures = 0;
   int   q0[$];
   int   q1[$];

   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.REG_AW(5), .PIPE_DEPTH(3), .CNT_W(16)) ifa ();
   hazard_scoreboard_unit_if #(.REG_AW(5), .PIPE_DEPTH(5), .CNT_W(16)) ifb ();

   hazard_scoreboard_unit #(.REG_AW(5), .PIPE_DEPTH(3), .LOAD_LAT(1), .BR_STAGE(1), .CNT_W(16))
      dut0 (.clk(clk), .rst(rst0), .bus(ifa));
   hazard_scoreboard_unit #(.REG_AW(5), .PIPE_DEPTH(5), .LOAD_LAT(3), .BR_STAGE(1), .CNT_W(16))
      dut1 (.clk(clk), .rst(rst1), .bus(ifb));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      int e;
      if (ifa.ex_valid) begin
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL ex0_unexpected actual=valid required=bubble");
         end else begin
            e = q0.pop_front();
            chk("fwd_a0", int'(ifa.fwd_a), e / 16);
            chk("fwd_b0", int'(ifa.fwd_b), e % 16);
         end
      end
      if (ifb.ex_valid) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL ex1_unexpected actual=valid required=bubble");
         end else begin
            e = q1.pop_front();
            chk("fwd_a1", int'(ifb.fwd_a), e / 16);
            chk("fwd_b1", int'(ifb.fwd_b), e % 16);
         end
      end
   end

   task automatic drive(input bit d1, input bit v, input int rs, input int rt, input bit urt,
                        input int rd, input bit wr, input bit ld, input bit fl);
      if (!d1) begin
         ifa.id_valid = v; ifa.id_rs = 5'(rs); ifa.id_rt = 5'(rt); ifa.id_uses_rt = urt;
         ifa.id_rd = 5'(rd); ifa.id_reg_write = wr; ifa.id_mem_read = ld; ifa.flush = fl;
      end else begin
         ifb.id_valid = v; ifb.id_rs = 5'(rs); ifb.id_rt = 5'(rt); ifb.id_uses_rt = urt;
         ifb.id_rd = 5'(rd); ifb.id_reg_write = wr; ifb.id_mem_read = ld; ifb.flush = fl;
      end
   endtask

   function automatic int stall_of(input bit d1);
      return d1 ? int'(ifb.stall) : int'(ifa.stall);
   endfunction

   // Hold the instruction in ID for nst stall cycles, then expect it to enter EX with (fa, fb).
   task automatic issue(input bit d1, input int rs, input int rt, input bit urt, input int rd,
                        input bit wr, input bit ld, input int nst, input int fa, input int fb);
      drive(d1, 1'b1, rs, rt, urt, rd, wr, ld, 1'b0);
      for (int i = 0; i <= nst; i++) begin
         @(negedge clk);
         chk(d1 ? "stall1" : "stall0", stall_of(d1), (i < nst) ? 1 : 0);
         if (i == nst) begin
            if (d1) q1.push_back(fa * 16 + fb);
            else    q0.push_back(fa * 16 + fb);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input bit d1, input int n);
      drive(d1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input bit d1);
      if (!d1) begin
         chk("rst_stall0", int'(ifa.stall), 0);       chk("rst_fwd_a0", int'(ifa.fwd_a), 0);
         chk("rst_fwd_b0", int'(ifa.fwd_b), 0);       chk("rst_exv0", int'(ifa.ex_valid), 0);
         chk("rst_scnt0", int'(ifa.stall_count), 0);  chk("rst_fcnt0", int'(ifa.flush_count), 0);
      end else begin
         chk("rst_stall1", int'(ifb.stall), 0);       chk("rst_fwd_a1", int'(ifb.fwd_a), 0);
         chk("rst_fwd_b1", int'(ifb.fwd_b), 0);       chk("rst_exv1", int'(ifb.ex_valid), 0);
         chk("rst_scnt1", int'(ifb.stall_count), 0);  chk("rst_fcnt1", int'(ifb.flush_count), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_zero(1'b0);
      chk_zero(1'b1);
      rst0 = 1'b1; rst1 = 1'b1;
      idle(1'b0, 1);

      // T1: LW r2 ; ADD r3,r2,r4 -> one stall, then forward from WB
      issue(1'b0, 1, 0, 1'b0, 2, 1'b1, 1'b1, 0, 0, 0);
      issue(1'b0, 2, 4, 1'b1, 3, 1'b1, 1'b0, 1, 2, 0);
      idle(1'b0, 4);
      chk("t1_scnt", int'(ifa.stall_count), 1);

      // T2: ALU chain, no stalls
      issue(1'b0, 1, 1, 1'b1, 5, 1'b1, 1'b0, 0, 0, 0);
      issue(1'b0, 5, 5, 1'b1, 6, 1'b1, 1'b0, 0, 1, 1);
      issue(1'b0, 5, 0, 1'b1, 7, 1'b1, 1'b0, 0, 2, 0);
      idle(1'b0, 4);

      // T3: two writers of r8, youngest wins
      issue(1'b0, 1, 1, 1'b1, 8, 1'b1, 1'b0, 0, 0, 0);
      issue(1'b0, 2, 2, 1'b1, 8, 1'b1, 1'b0, 0, 0, 0);
      issue(1'b0, 8, 0, 1'b1, 9, 1'b1, 1'b0, 0, 1, 0);
      idle(1'b0, 4);

      // T4: r0 is never a hazard; also a load writing r0
      issue(1'b0, 1, 2, 1'b1, 0, 1'b1, 1'b1, 0, 0, 0);
      issue(1'b0, 0, 0, 1'b1, 10, 1'b1, 1'b0, 0, 0, 0);
      idle(1'b0, 4);
      chk("t4_scnt", int'(ifa.stall_count), 1);

      // T5: flush coincident with a load-use stall
      issue(1'b0, 1, 0, 1'b0, 11, 1'b1, 1'b1, 0, 0, 0);
      drive(1'b0, 1'b1, 11, 11, 1'b1, 12, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_stall", int'(ifa.stall), 0);
      chk("t5_fcnt_pre", int'(ifa.flush_count), 0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_exv", int'(ifa.ex_valid), 0);
      chk("t5_fcnt", int'(ifa.flush_count), 1);
      chk("t5_scnt", int'(ifa.stall_count), 1);
      idle(1'b0, 4);

      // T6: deep pipe, load latency 3 -> three stalls, forward from entry 4
      issue(1'b1, 1, 0, 1'b0, 2, 1'b1, 1'b1, 0, 0, 0);
      issue(1'b1, 2, 4, 1'b1, 3, 1'b1, 1'b0, 3, 4, 0);
      idle(1'b1, 6);
      chk("t6_scnt", int'(ifb.stall_count), 3);

      // Reset while a load-use stall is active
      issue(1'b1, 1, 0, 1'b0, 2, 1'b1, 1'b1, 0, 0, 0);
      drive(1'b1, 1'b1, 2, 4, 1'b1, 3, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t6_stall_pre", int'(ifb.stall), 1);
      #1 rst1 = 1'b0;
      #1 chk_zero(1'b1);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst1 = 1'b1;
      idle(1'b1, 2);

      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order pipeline. It generalises the fixed EX/MEM/WB load-use stall and the two-source forwarding decode to a configurable post-ID depth, load latency and branch-resolve stage.
- A shift-register scoreboard tracks the destination, load flag and validity of every in-flight instruction.
- Its outputs drive the PC/IF-ID enables, the ID/EX bubble insertion and the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width.
- PIPE_DEPTH, 3, stages tracked after ID (entry 0=EX … PIPE_DEPTH-1=WB); legal range 2..8.
- LOAD_LAT, 1, stages after EX before load data is forwardable; legal range 1..PIPE_DEPTH-2.
- BR_STAGE, 1, entry index where a taken branch resolves; flush kills entries below it plus ID; legal range 0..PIPE_DEPTH-1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source A address.
- id_rt  in  REG_AW  ID source B address.
- id_uses_rt  in  1  id_rt is a true source (not an immediate op).
- id_rd  in  REG_AW  final destination (RegDst already applied).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  taken branch resolved at entry BR_STAGE this cycle.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_a  out  $clog2(PIPE_DEPTH)  EX operand A source: 0=regfile/ID/EX latch, k=result of entry k.
- fwd_b  out  $clog2(PIPE_DEPTH)  EX operand B source, same encoding.
- ex_valid  out  1  entry 0 holds a real instruction.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush events.

Behaviour:
- Entry format: {valid, wr, rd, is_load, src_a, src_b, use_b}. Entry k is "producer-ready" when valid & wr & rd!=0 & k >= avail, where avail=1 for ALU ops and avail=LOAD_LAT+1 for loads.
- rst low: all entries are cleared immediately (asynchronous). stall=0, fwd_a=fwd_b=0, ex_valid=0, counters=0.
- Stall (combinational):
  - Asserted when id_valid and some entry k is valid & wr & rd!=0 & rd matches id_rs (or id_rt when id_uses_rt) & (k+1) < avail.
  - Default parameters: load in EX with dependent instruction in ID → exactly 1 stall cycle; ALU producer → 0 stall cycles.
  - An address of 0 never causes a stall or a forward.
- Shift each cycle: entries k → k+1; entry PIPE_DEPTH-1 retires.
- Entry 0 load:
  - If stall or flush or !id_valid, entry 0 loads a bubble (valid=0).
  - Otherwise entry 0 loads the ID fields.
- Flush:
  - Takes priority over stall: stall is forced to 0 during a flush cycle.
  - Entries 0..BR_STAGE-1 are invalidated in the same edge, after the shift; ID is dropped.
  - Entries at or beyond BR_STAGE are unaffected.
- Forwarding (combinational from entry-0 sources):
  - fwd_a = smallest k in 1..PIPE_DEPTH-1 where entry k is producer-ready and rd == entry0.src_a, else 0. The youngest producer wins.
  - fwd_b is computed the same way using src_b, gated by use_b.
  - Both are 0 when entry 0 is invalid.
  - A non-ready matching entry yields 0; a correct stall prevents this from occurring.
- Counters:
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with flush=1.
  - Both saturate at all-ones; they do not wrap.
- Simultaneous flush and stall: the flush outcome applies, stall_count is unchanged, and flush_count increments.
- Reset mid-stall: all state clears and stall drops immediately, without waiting for a clock edge.
- An out-of-range parameter value is a compile-time error, raised from a generate-time check.

Test Plan:
- Test 1: LW r2 issued, then ADD r3,r2,r4 in the next cycle.
  - stall=1 for exactly 1 cycle; entry 0 holds a bubble.
  - When ADD reaches EX, fwd_a=2 (WB); stall_count=1.
- Test 2: ADD r5,r1,r1; SUB r6,r5,r5; OR r7,r5,r0 issued back-to-back.
  - No stall.
  - SUB in EX: fwd_a=fwd_b=1. OR in EX: fwd_a=2, fwd_b=0.
- Test 3: Two writers to r8 back-to-back, then a reader.
  - Reader in EX gets fwd_a=1 (youngest producer), not 2.
- Test 4: Producer writes r0, then a consumer of r0.
  - No stall; fwd_a=fwd_b=0.
- Test 5: flush=1 coincident with a load-use stall (BR_STAGE=1).
  - stall=0; entry 0 is invalid next cycle; ex_valid=0; flush_count=1.
- Test 6: PIPE_DEPTH=5, LOAD_LAT=3; load followed by a dependent instruction.
  - 3 stall cycles, then fwd=4.
  - Then assert rst low mid-stall: stall drops within the same cycle and all outputs read 0.
